// File: rtl/scpad_pkg.sv
// Shared widths, request/completion record types and lane-masking helper for the
// DRAM backend responder.
package scpad_pkg;

    localparam int unsigned DRAM_ID_W   = 8;
    localparam int unsigned DRAM_ADDR_W = 32;
    localparam int unsigned DRAM_LANES  = 4;
    localparam int unsigned LANE_W      = 32;
    localparam int unsigned DATA_W      = DRAM_LANES * LANE_W;

    typedef struct packed {
        logic                   write;
        logic [DRAM_ID_W-1:0]   id;
        logic [DRAM_ADDR_W-1:0] addr;
        logic [DRAM_LANES-1:0]  mask;
        logic [DATA_W-1:0]      wdata;
    } dram_req_t;

    typedef struct packed {
        logic [DRAM_ID_W-1:0]  id;
        logic                  write;
        logic [DRAM_LANES-1:0] mask;
        logic [DATA_W-1:0]     rdata;
        logic                  done;
    } dram_cpl_t;

    // Zero every 32-bit lane whose enable bit is clear.
    function automatic logic [DATA_W-1:0] mask_lanes(input logic [DATA_W-1:0]     data,
                                                     input logic [DRAM_LANES-1:0] mask);
        logic [DATA_W-1:0] out;
        out = '0;
        for (int l = 0; l < DRAM_LANES; l++) begin
            if (mask[l]) out[l*LANE_W +: LANE_W] = data[l*LANE_W +: LANE_W];
        end
        return out;
    endfunction

endpackage

// File: rtl/scpad_sync_fifo.sv
// Synchronous FIFO of an arbitrary packed type; push when full and pop when empty are ignored.
module scpad_sync_fifo #(
    parameter type         T     = logic,
    parameter int unsigned Depth = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  T                       data_i,
    input  logic                   pop_i,
    output T                       data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] count_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        cnt_d = cnt_q + CntW'(do_push) - CntW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dram_be_responder.sv
// Backend-to-memory responder: queues requests, issues them to memory and returns
// read data / write acks to the backend in strict issue order.
module dram_be_responder
    import scpad_pkg::*;
#(
    parameter int unsigned REQ_DEPTH = 4,
    parameter int unsigned CPL_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [DRAM_ID_W-1:0]   req_id,
    input  logic [DRAM_ADDR_W-1:0] req_addr,
    input  logic [DRAM_LANES-1:0]  req_mask,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   dram_be_stall,
    input  logic                   be_dram_stall,
    output logic                   res_valid,
    output logic                   res_write,
    output logic [DRAM_ID_W-1:0]   res_id,
    output logic [DATA_W-1:0]      res_rdata,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_write,
    output logic [DRAM_ADDR_W-1:0] mem_addr,
    output logic [DRAM_LANES-1:0]  mem_wmask,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic                   mem_rsp_valid,
    input  logic [DATA_W-1:0]      mem_rdata
);

    localparam int unsigned PTR_W  = $clog2(CPL_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned RCNT_W = $clog2(REQ_DEPTH) + 1;

    dram_req_t         push_req, head_req;
    logic              req_accept, req_full, req_empty, issue;
    logic [RCNT_W-1:0] req_cnt;

    dram_cpl_t        cpl_q [CPL_DEPTH];
    dram_cpl_t        head_cpl;
    logic [PTR_W-1:0] cpl_head_q, cpl_tail_q, fill_idx;
    logic [CNT_W-1:0] cpl_cnt_q, cpl_cnt_d;
    logic             cpl_free, res_pop, fill_hit, err_q;

    assign push_req      = '{write: req_write, id: req_id, addr: req_addr, mask: req_mask,
                             wdata: req_wdata};
    assign dram_be_stall = req_full;
    assign req_accept    = req_valid && !dram_be_stall;

    scpad_sync_fifo #(
        .T     (dram_req_t),
        .Depth (REQ_DEPTH)
    ) u_req_fifo (
        .clk_i   (clk),
        .rst_ni  (n_rst),
        .push_i  (req_accept),
        .data_i  (push_req),
        .pop_i   (issue),
        .data_o  (head_req),
        .full_o  (req_full),
        .empty_o (req_empty),
        .count_o (req_cnt)
    );

    assign head_cpl  = cpl_q[cpl_head_q];
    assign res_valid = (cpl_cnt_q != '0) && head_cpl.done;
    assign res_pop   = res_valid && !be_dram_stall;
    // A popping head frees its slot for a same-cycle reservation.
    assign cpl_free  = (cpl_cnt_q != CNT_W'(CPL_DEPTH)) || res_pop;

    assign mem_req_valid = !req_empty && cpl_free;
    assign issue         = mem_req_valid && mem_req_ready;
    assign mem_write     = mem_req_valid && head_req.write;
    assign mem_addr      = mem_req_valid ? head_req.addr  : '0;
    assign mem_wmask     = mem_req_valid ? head_req.mask  : '0;
    assign mem_wdata     = mem_req_valid ? head_req.wdata : '0;

    assign res_write = res_valid && head_cpl.write;
    assign res_id    = res_valid ? head_cpl.id : '0;
    assign res_rdata = (res_valid && !head_cpl.write) ? head_cpl.rdata : '0;

    // Writes complete at reservation, so the oldest not-done slot is the oldest pending read.
    always_comb begin
        logic [PTR_W-1:0] idx;
        fill_hit = 1'b0;
        fill_idx = '0;
        idx      = '0;
        for (int i = 0; i < CPL_DEPTH; i++) begin
            idx = cpl_head_q + PTR_W'(i);
            if (!fill_hit && (CNT_W'(i) < cpl_cnt_q) && !cpl_q[idx].done) begin
                fill_hit = 1'b1;
                fill_idx = idx;
            end
        end
        cpl_cnt_d = cpl_cnt_q + CNT_W'(issue) - CNT_W'(res_pop);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cpl_head_q <= '0;
            cpl_tail_q <= '0;
            cpl_cnt_q  <= '0;
            err_q      <= 1'b0;
            for (int i = 0; i < CPL_DEPTH; i++) cpl_q[i] <= '0;
        end else begin
            if (issue) begin
                cpl_q[cpl_tail_q] <= '{id: head_req.id, write: head_req.write,
                                       mask: head_req.mask, rdata: '0, done: head_req.write};
                cpl_tail_q        <= cpl_tail_q + 1'b1;
            end
            if (mem_rsp_valid) begin
                if (fill_hit) begin
                    cpl_q[fill_idx].rdata <= mask_lanes(mem_rdata, cpl_q[fill_idx].mask);
                    cpl_q[fill_idx].done  <= 1'b1;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (res_pop) cpl_head_q <= cpl_head_q + 1'b1;
            cpl_cnt_q <= cpl_cnt_d;
        end
    end

    a_err_sticky: assert property (@(posedge clk) disable iff (!n_rst) err_q |=> err_q);
    a_cnt_bound: assert property (@(posedge clk) disable iff (!n_rst)
        (cpl_cnt_q <= CNT_W'(CPL_DEPTH)) && (req_cnt <= RCNT_W'(REQ_DEPTH)));

endmodule

// File: tb/tb_dram_be_responder.sv
// Directed bench for dram_be_responder: inputs driven on the falling edge, outputs
// checked 1ns later, expected values hand-computed per scenario.
module tb_dram_be_responder;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         req_valid, req_write;
    logic [7:0]   req_id;
    logic [31:0]  req_addr;
    logic [3:0]   req_mask;
    logic [127:0] req_wdata;
    logic         dram_be_stall, be_dram_stall;
    logic         res_valid, res_write;
    logic [7:0]   res_id;
    logic [127:0] res_rdata;
    logic         mem_req_valid, mem_req_ready, mem_write;
    logic [31:0]  mem_addr;
    logic [3:0]   mem_wmask;
    logic [127:0] mem_wdata;
    logic         mem_rsp_valid;
    logic [127:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dram_be_responder dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_id        (req_id),
        .req_addr      (req_addr),
        .req_mask      (req_mask),
        .req_wdata     (req_wdata),
        .dram_be_stall (dram_be_stall),
        .be_dram_stall (be_dram_stall),
        .res_valid     (res_valid),
        .res_write     (res_write),
        .res_id        (res_id),
        .res_rdata     (res_rdata),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wmask     (mem_wmask),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    task automatic drive_req(input logic w, input logic [7:0] id, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [127:0] wdata);
        req_valid = 1'b1;
        req_write = w;
        req_id    = id;
        req_addr  = addr;
        req_mask  = mask;
        req_wdata = wdata;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        req_valid = 0; req_write = 0; req_id = 0; req_addr = 0; req_mask = 0; req_wdata = 0;
        be_dram_stall = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        settle(); #1;
        checks++;
        if ({dram_be_stall, res_valid, mem_req_valid, res_write, mem_write} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00000",
                     {dram_be_stall, res_valid, mem_req_valid, res_write, mem_write});
        end
        checks++;
        if ({res_id, res_rdata, mem_addr, mem_wmask, mem_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: res_id %h mem_addr %h nonzero, required 0", res_id, mem_addr);
        end
        checks++;
        if (dut.err_q !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b required 0", dut.err_q);
        end
        n_rst = 1'b1;
    endtask

    task automatic test_write();
        settle();
        mem_req_ready = 1'b1;
        drive_req(1'b1, 8'h08, 32'h100, 4'hf, 128'h44444444_33333333_22222222_11111111);
        #1;
        checks++;
        if (dram_be_stall !== 1'b0) begin
            errors++; $display("FAIL wr_stall: got %b required 0", dram_be_stall);
        end
        settle(); req_valid = 1'b0; #1;
        checks++;
        if ({mem_req_valid, mem_write, mem_addr, mem_wmask} !== {2'b11, 32'h100, 4'hf}) begin
            errors++;
            $display("FAIL wr_issue: got v%b w%b a%h m%h required v1 w1 a100 mf",
                     mem_req_valid, mem_write, mem_addr, mem_wmask);
        end
        checks++;
        if (mem_wdata !== 128'h44444444_33333333_22222222_11111111) begin
            errors++; $display("FAIL wr_wdata: got %h", mem_wdata);
        end
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL wr_early_res: got %b required 0", res_valid);
        end
        settle(); #1;
        checks++;
        if ({res_valid, res_write, res_id, res_rdata} !== {2'b11, 8'h08, 128'h0}) begin
            errors++;
            $display("FAIL wr_ack: got v%b w%b id%h d%h required v1 w1 id08 d0",
                     res_valid, res_write, res_id, res_rdata);
        end
        settle(); #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL wr_ack_pop: got %b required 0", res_valid);
        end
    endtask

    task automatic test_read_mask();
        settle();
        drive_req(1'b0, 8'h10, 32'h200, 4'b0011, 128'h0);
        settle(); req_valid = 1'b0; #1;
        checks++;
        if ({mem_req_valid, mem_write, mem_addr, mem_wmask} !== {2'b10, 32'h200, 4'b0011}) begin
            errors++;
            $display("FAIL rd_issue: got v%b w%b a%h m%h required v1 w0 a200 m3",
                     mem_req_valid, mem_write, mem_addr, mem_wmask);
        end
        settle();
        mem_rsp_valid = 1'b1;
        mem_rdata = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL rd_early_res: got %b required 0", res_valid);
        end
        settle(); mem_rsp_valid = 1'b0; #1;
        checks++;
        if ({res_valid, res_write, res_id} !== {2'b10, 8'h10}) begin
            errors++;
            $display("FAIL rd_res: got v%b w%b id%h required v1 w0 id10", res_valid, res_write, res_id);
        end
        checks++;
        if (res_rdata !== 128'h00000000_00000000_BBBBBBBB_AAAAAAAA) begin
            errors++; $display("FAIL rd_mask: got %h required 0_0_BBBBBBBB_AAAAAAAA", res_rdata);
        end
        settle(); #1;
    endtask

    task automatic test_fifo_full();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            drive_req(1'b1, 8'h20 + 8'(i), 32'h300 + 32'(i), 4'hf, 128'(i));
            #1;
            checks++;
            if (dram_be_stall !== (i == 4)) begin
                errors++; $display("FAIL full_stall%0d: got %b required %b", i, dram_be_stall, i == 4);
            end
        end
        settle(); req_valid = 1'b0; mem_req_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            checks++;
            if ({mem_req_valid, mem_addr} !== {1'b1, 32'h300 + 32'(j)}) begin
                errors++;
                $display("FAIL drain_issue%0d: got v%b a%h required v1 a%h", j, mem_req_valid,
                         mem_addr, 32'h300 + 32'(j));
            end
            checks++;
            if (dram_be_stall !== (j == 0)) begin
                errors++; $display("FAIL drain_stall%0d: got %b required %b", j, dram_be_stall, j == 0);
            end
            if (j > 0) begin
                checks++;
                if ({res_valid, res_id} !== {1'b1, 8'h20 + 8'(j - 1)}) begin
                    errors++;
                    $display("FAIL drain_res%0d: got v%b id%h required v1 id%h", j, res_valid,
                             res_id, 8'h20 + 8'(j - 1));
                end
            end
            settle();
        end
        #1;
        checks++;
        if ({mem_req_valid, res_valid, res_id} !== {2'b01, 8'h23}) begin
            errors++;
            $display("FAIL drain_last: got mv%b rv%b id%h required mv0 rv1 id23",
                     mem_req_valid, res_valid, res_id);
        end
        settle(); #1;
    endtask

    task automatic test_order();
        settle();
        drive_req(1'b0, 8'h30, 32'h400, 4'hf, 128'h0);
        settle();
        drive_req(1'b1, 8'h31, 32'h404, 4'hf, 128'h5);
        #1;
        checks++;
        if ({mem_req_valid, mem_write, mem_addr} !== {2'b10, 32'h400}) begin
            errors++; $display("FAIL ord_issue_a: got v%b w%b a%h", mem_req_valid, mem_write, mem_addr);
        end
        settle(); req_valid = 1'b0; #1;
        checks++;
        if ({mem_req_valid, mem_write, mem_addr} !== {2'b11, 32'h404}) begin
            errors++; $display("FAIL ord_issue_b: got v%b w%b a%h", mem_req_valid, mem_write, mem_addr);
        end
        for (int k = 0; k < 8; k++) begin
            settle(); #1;
            checks++;
            if (res_valid !== 1'b0) begin
                errors++; $display("FAIL ord_wait%0d: res_valid got %b required 0", k, res_valid);
            end
        end
        settle();
        mem_rsp_valid = 1'b1;
        mem_rdata = 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978;
        settle(); mem_rsp_valid = 1'b0; #1;
        checks++;
        if ({res_valid, res_write, res_id} !== {2'b10, 8'h30}) begin
            errors++; $display("FAIL ord_a: got v%b w%b id%h required v1 w0 id30", res_valid, res_write, res_id);
        end
        checks++;
        if (res_rdata !== 128'h12345678_9ABCDEF0_0F1E2D3C_4B5A6978) begin
            errors++; $display("FAIL ord_a_data: got %h", res_rdata);
        end
        settle(); #1;
        checks++;
        if ({res_valid, res_write, res_id} !== {2'b11, 8'h31}) begin
            errors++; $display("FAIL ord_b: got v%b w%b id%h required v1 w1 id31", res_valid, res_write, res_id);
        end
        settle(); #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL ord_empty: got %b required 0", res_valid);
        end
    endtask

    task automatic test_back_to_back();
        be_dram_stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            settle();
            drive_req(1'b1, 8'h40 + 8'(k), 32'h500 + 32'(k), 4'hf, 128'h0);
        end
        settle(); req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if ({res_valid, res_id, mem_req_valid} !== {1'b1, 8'h40, 1'b0}) begin
                errors++;
                $display("FAIL hold%0d: got rv%b id%h mv%b required rv1 id40 mv0", k, res_valid,
                         res_id, mem_req_valid);
            end
            settle();
        end
        be_dram_stall = 1'b0;
        #1;
        checks++;
        if ({mem_req_valid, mem_addr} !== {1'b1, 32'h504}) begin
            errors++; $display("FAIL release_issue: got v%b a%h required v1 a504", mem_req_valid, mem_addr);
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({res_valid, res_write, res_id} !== {2'b11, 8'h40 + 8'(k)}) begin
                errors++;
                $display("FAIL b2b%0d: got v%b w%b id%h required v1 w1 id%h", k, res_valid,
                         res_write, res_id, 8'h40 + 8'(k));
            end
            settle(); #1;
        end
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_empty: got %b required 0", res_valid);
        end
    endtask

    task automatic test_mid_reset();
        settle();
        drive_req(1'b0, 8'h50, 32'h600, 4'hf, 128'h0);
        settle();
        drive_req(1'b0, 8'h51, 32'h604, 4'hf, 128'h0);
        settle(); req_valid = 1'b0;
        settle(); n_rst = 1'b0;
        settle(); #1;
        checks++;
        if ({dram_be_stall, res_valid, mem_req_valid, res_id, mem_addr, res_rdata} !== '0) begin
            errors++;
            $display("FAIL mid_reset_out: stall%b rv%b mv%b id%h a%h required all 0",
                     dram_be_stall, res_valid, mem_req_valid, res_id, mem_addr);
        end
        n_rst = 1'b1;
        settle();
        mem_rsp_valid = 1'b1;
        mem_rdata = 128'hFFFF;
        settle(); mem_rsp_valid = 1'b0; #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL late_rsp: res_valid got %b required 0", res_valid);
        end
        checks++;
        if (dut.err_q !== 1'b1) begin
            errors++; $display("FAIL late_rsp_err: got %b required 1", dut.err_q);
        end
        settle(); #1;
        checks++;
        if ({res_valid, mem_req_valid} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: got rv%b mv%b required 00", res_valid, mem_req_valid);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_mask();
        test_fifo_full();
        test_order();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
